// File: rtl/dot_fp_seq.sv
// dot_fp_seq: streams beats of k element pairs through one dot unit and
// accumulates the partial sums of a vector into a widened accumulator.
// Each vector returns one result, with sticky NaN and block-overflow
// flags, on a valid/ready handshake.
//
// state | meaning
// ------+---------------------------------------------------------------
// ACC   | accepting beats; the beat flagged last moves the FSM to DRAIN
// DRAIN | no beats taken; the last beat folds from p1 into acc
// OUT   | result held on o_dp/o_nan/o_ovf until i_ready, then cleared
module dot_fp_seq #(
    parameter  int exp_width = 5,
    parameter  int man_width = 2,
    parameter  int k         = 32,
    parameter  int max_blk   = 8,
    localparam int bit_width = 1 + exp_width + man_width,
    localparam int out_width = 2 * ((1 << exp_width) + man_width) + $clog2(k),
    localparam int acc_width = out_width + $clog2(max_blk) + 1
) (
    input  logic                               i_clk,
    input  logic                               i_rst,
    input  logic [k-1:0][bit_width-1:0]        i_vec_a,
    input  logic [k-1:0][bit_width-1:0]        i_vec_b,
    input  logic                               i_valid,
    input  logic                               i_last,
    output logic                               o_ready,
    output logic signed [acc_width-1:0]        o_dp,
    output logic                               o_nan,
    output logic                               o_ovf,
    output logic                               o_valid,
    input  logic                               i_ready
);

    localparam int cnt_width = $clog2(max_blk + 1);

    typedef enum logic [1:0] {
        ACC   = 2'd0,
        DRAIN = 2'd1,
        OUT   = 2'd2
    } state_t;

    state_t                      state;
    logic                        ready_r;
    logic                        valid_r;

    logic signed [out_width-1:0] dot_sum;
    logic                        dot_nan;

    logic signed [out_width-1:0] p1_sum;
    logic                        p1_valid;
    logic                        p1_add;
    logic                        p1_nan;
    logic                        p1_last;

    logic signed [acc_width-1:0] acc;
    logic [cnt_width-1:0]        blk_cnt;
    logic                        nan_r;
    logic                        ovf_r;

    logic                        accept;
    logic                        cnt_full;
    logic                        out_done;

    // o_ready is registered but masked while reset is held so no beat slips in.
    assign o_ready  = ready_r & ~i_rst;
    assign accept   = i_valid & o_ready;
    assign cnt_full = (blk_cnt == cnt_width'(max_blk));
    assign out_done = (state == OUT) & i_ready;

    assign o_valid  = valid_r;
    assign o_nan    = nan_r;
    assign o_ovf    = ovf_r;
    assign o_dp     = nan_r ? '0 : acc;

    dot_fp_spec #(
        .exp_width (exp_width),
        .man_width (man_width),
        .k         (k)
    ) u_dot (
        .i_vec_a (i_vec_a),
        .i_vec_b (i_vec_b),
        .o_sum   (dot_sum),
        .o_nan   (dot_nan)
    );

    // Stage 1: register the dot unit result of every accepted beat.
    // p1_add is cleared for beats arriving after the block limit, so they
    // still contribute their NaN flag but not their sum.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            p1_valid <= 1'b0;
            p1_add   <= 1'b0;
            p1_nan   <= 1'b0;
            p1_last  <= 1'b0;
            p1_sum   <= '0;
        end else begin
            p1_valid <= accept;
            p1_add   <= ~cnt_full;
            p1_nan   <= dot_nan;
            p1_last  <= i_last;
            if (accept) begin
                p1_sum <= dot_sum;
            end
        end
    end

    // Stage 2: fold p1 into the sign-extended accumulator and keep the NaN flag.
    always_ff @(posedge i_clk) begin
        if (i_rst || out_done) begin
            acc   <= '0;
            nan_r <= 1'b0;
        end else if (p1_valid) begin
            if (p1_add) begin
                acc <= acc + $signed({{(acc_width - out_width){p1_sum[out_width-1]}}, p1_sum});
            end
            if (p1_nan) begin
                nan_r <= 1'b1;
            end
        end
    end

    // Beat counter saturates at max_blk; any further beat marks overflow.
    always_ff @(posedge i_clk) begin
        if (i_rst || out_done) begin
            blk_cnt <= '0;
            ovf_r   <= 1'b0;
        end else if (accept) begin
            if (cnt_full) begin
                ovf_r <= 1'b1;
            end else begin
                blk_cnt <= blk_cnt + cnt_width'(1);
            end
        end
    end

    // Vector sequencing FSM with registered ready/valid.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= ACC;
            ready_r <= 1'b1;
            valid_r <= 1'b0;
        end else begin
            case (state)
                ACC: begin
                    if (accept && i_last) begin
                        state   <= DRAIN;
                        ready_r <= 1'b0;
                    end
                end
                DRAIN: begin
                    // p1 always holds the last beat here; acc is final at this edge.
                    if (p1_valid && p1_last) begin
                        state   <= OUT;
                        valid_r <= 1'b1;
                    end
                end
                OUT: begin
                    if (i_ready) begin
                        state   <= ACC;
                        valid_r <= 1'b0;
                        ready_r <= 1'b1;
                    end
                end
                default: begin
                    state   <= ACC;
                    ready_r <= 1'b1;
                    valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// dot_fp_spec: combinational k-wide floating-point dot product.
// Each element becomes an unsigned fixed-point magnitude sig << (e_eff-1),
// with e_eff = 1 for subnormals, so one LSB of the product is 2^-(2*(bias+man-1)).
// A product of 1.0 x 1.0 therefore lands at 2^(2*(bias+man-1)).
// Elements with an all-ones exponent (inf/NaN) raise o_nan.
module dot_fp_spec #(
    parameter  int exp_width = 5,
    parameter  int man_width = 2,
    parameter  int k         = 32,
    localparam int bit_width = 1 + exp_width + man_width,
    localparam int out_width = 2 * ((1 << exp_width) + man_width) + $clog2(k)
) (
    input  logic [k-1:0][bit_width-1:0] i_vec_a,
    input  logic [k-1:0][bit_width-1:0] i_vec_b,
    output logic signed [out_width-1:0] o_sum,
    output logic                        o_nan
);

    localparam int fx_width = (1 << exp_width) + man_width;

    function automatic logic is_special(input logic [bit_width-1:0] e);
        return &e[bit_width-2 -: exp_width];
    endfunction

    function automatic logic [fx_width-1:0] to_fixed(input logic [bit_width-1:0] e);
        logic [exp_width-1:0] ex;
        logic [man_width:0]   sig;
        logic [exp_width-1:0] sh;
        ex  = e[bit_width-2 -: exp_width];
        sig = {(ex != '0), e[man_width-1:0]};
        sh  = (ex == '0) ? '0 : ex - exp_width'(1);
        return fx_width'(sig) << sh;
    endfunction

    logic [out_width-1:0] mag;

    // Signed sum of the k element products plus the OR of special operands.
    always_comb begin
        o_sum = '0;
        o_nan = 1'b0;
        mag   = '0;
        for (int i = 0; i < k; i++) begin
            mag = out_width'(to_fixed(i_vec_a[i])) * out_width'(to_fixed(i_vec_b[i]));
            if (i_vec_a[i][bit_width-1] ^ i_vec_b[i][bit_width-1]) begin
                o_sum = o_sum - $signed(mag);
            end else begin
                o_sum = o_sum + $signed(mag);
            end
            o_nan = o_nan | is_special(i_vec_a[i]) | is_special(i_vec_b[i]);
        end
    end

endmodule

// File: tb/tb_dot_fp_seq.sv
// Bench for dot_fp_seq: directed cases plus random vectors, with a
// scoreboard queue filled by the driver and drained by an output monitor.
module tb_dot_fp_seq;

    localparam int EW      = 5;
    localparam int MW      = 2;
    localparam int K       = 32;
    localparam int MAX_BLK = 8;
    localparam int BW      = 1 + EW + MW;
    localparam int OUT_W   = 2 * ((1 << EW) + MW) + $clog2(K);
    localparam int ACC_W   = OUT_W + $clog2(MAX_BLK) + 1;
    localparam int BIAS    = (1 << (EW - 1)) - 1;
    // o_dp is the real dot product scaled by 2^SCALE.
    localparam int SCALE   = 2 * (BIAS + MW - 1);

    typedef logic [K-1:0][BW-1:0] beat_t;
    typedef struct {
        logic signed [127:0] dp;
        logic                nan;
        logic                ovf;
    } res_t;

    logic               i_clk;
    logic               i_rst;
    beat_t              i_vec_a;
    beat_t              i_vec_b;
    logic               i_valid;
    logic               i_last;
    logic               o_ready;
    logic signed [ACC_W-1:0] o_dp;
    logic               o_nan;
    logic               o_ovf;
    logic               o_valid;
    logic               i_ready;

    dot_fp_seq #(
        .exp_width (EW),
        .man_width (MW),
        .k         (K),
        .max_blk   (MAX_BLK)
    ) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_vec_a (i_vec_a),
        .i_vec_b (i_vec_b),
        .i_valid (i_valid),
        .i_last  (i_last),
        .o_ready (o_ready),
        .o_dp    (o_dp),
        .o_nan   (o_nan),
        .o_ovf   (o_ovf),
        .o_valid (o_valid),
        .i_ready (i_ready)
    );

    int   total = 0;
    int   bad   = 0;
    res_t exp_q[$];
    logic signed [127:0] last_dp;
    logic last_nan;
    logic last_ovf;
    logic rand_rdy;
    beat_t va [16];
    beat_t vb [16];

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic check(input string name, input logic signed [127:0] act,
                         input logic signed [127:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    function automatic beat_t fill(input logic [BW-1:0] x);
        beat_t f;
        for (int i = 0; i < K; i++) f[i] = x;
        return f;
    endfunction

    function automatic logic [BW-1:0] rand_elem();
        logic          s;
        logic [EW-1:0] e;
        logic [MW-1:0] m;
        s = 1'($urandom_range(0, 1));
        e = EW'($urandom_range(0, (1 << EW) - 2));
        m = MW'($urandom_range(0, (1 << MW) - 1));
        if ($urandom_range(0, 399) == 0) e = '1;
        return {s, e, m};
    endfunction

    // Reference: real value of an element is (-1)^s * sig * 2^(e_eff-BIAS-MW),
    // so a product scaled by 2^SCALE is sig_a*sig_b*2^(ea+eb-2*(BIAS+MW)+SCALE).
    function automatic logic signed [127:0] beat_value(input beat_t a, input beat_t b,
                                                      output logic sp);
        logic signed [127:0] sum;
        logic signed [127:0] term;
        int sa, sb, ea, eb, fa, fb, sh;
        sum = 0;
        sp  = 1'b0;
        for (int i = 0; i < K; i++) begin
            fa = int'(a[i][BW-2 -: EW]);
            fb = int'(b[i][BW-2 -: EW]);
            if (fa == (1 << EW) - 1 || fb == (1 << EW) - 1) sp = 1'b1;
            sa = (fa == 0) ? int'(a[i][MW-1:0]) : (1 << MW) + int'(a[i][MW-1:0]);
            sb = (fb == 0) ? int'(b[i][MW-1:0]) : (1 << MW) + int'(b[i][MW-1:0]);
            ea = (fa == 0) ? 1 : fa;
            eb = (fb == 0) ? 1 : fb;
            sh = ea + eb - 2 * (BIAS + MW) + SCALE;
            term = 128'(sa * sb);
            term = term <<< sh;
            if (a[i][BW-1] ^ b[i][BW-1]) sum = sum - term;
            else sum = sum + term;
        end
        return sum;
    endfunction

    task automatic send_beat(input beat_t a, input beat_t b, input logic last);
        int guard;
        guard   = 0;
        i_vec_a = a;
        i_vec_b = b;
        i_last  = last;
        i_valid = 1'b1;
        forever begin
            @(negedge i_clk);
            if (o_ready) break;
            guard++;
            if (guard > 300) begin
                total++;
                bad++;
                $display("FAIL beat_accept_timeout: o_ready=%0d after %0d cycles, expected 1", o_ready, guard);
                break;
            end
        end
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        i_last  = 1'b0;
    endtask

    task automatic send_vec(input int n, input int gmin, input int gmax);
        res_t r;
        logic signed [127:0] sum;
        logic signed [127:0] bv;
        logic sp;
        logic any_sp;
        sum    = 0;
        any_sp = 1'b0;
        for (int i = 0; i < n; i++) begin
            bv = beat_value(va[i], vb[i], sp);
            any_sp = any_sp | sp;
            if (i < MAX_BLK) sum = sum + bv;
        end
        r.dp  = any_sp ? 128'sd0 : sum;
        r.nan = any_sp;
        r.ovf = (n > MAX_BLK);
        exp_q.push_back(r);
        for (int i = 0; i < n; i++) begin
            send_beat(va[i], vb[i], i == n - 1);
            if (i != n - 1) begin
                repeat ($urandom_range(gmin, gmax)) @(posedge i_clk);
                #1;
            end
        end
    endtask

    task automatic wait_results();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 400) begin
            @(posedge i_clk);
            t++;
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL result_timeout: %0d results pending, expected 0", exp_q.size());
            exp_q.delete();
        end
        #1;
    endtask

    task automatic wait_valid(input string name);
        int t;
        t = 0;
        while (!o_valid && t < 20) begin
            @(negedge i_clk);
            t++;
        end
        check(name, o_valid, 1);
    endtask

    // i_ready driver for the random phase.
    initial begin
        forever begin
            @(posedge i_clk);
            #1;
            if (rand_rdy) i_ready = ($urandom_range(0, 9) < 7);
        end
    end

    // Monitor: checks hold stability while stalled and pops the scoreboard on handshake.
    initial begin
        logic held;
        logic signed [ACC_W-1:0] h_dp;
        logic h_nan, h_ovf;
        res_t r;
        held = 1'b0;
        h_dp = '0;
        h_nan = 1'b0;
        h_ovf = 1'b0;
        forever begin
            @(negedge i_clk);
            if (i_rst) begin
                held = 1'b0;
            end else if (o_valid) begin
                if (held) begin
                    check("stable_dp", o_dp, h_dp);
                    check("stable_nan", o_nan, h_nan);
                    check("stable_ovf", o_ovf, h_ovf);
                end else begin
                    held  = 1'b1;
                    h_dp  = o_dp;
                    h_nan = o_nan;
                    h_ovf = o_ovf;
                end
                if (i_ready) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_result: dp=%0d with no vector outstanding", o_dp);
                    end else begin
                        r = exp_q.pop_front();
                        check("res_dp", o_dp, r.dp);
                        check("res_nan", o_nan, r.nan);
                        check("res_ovf", o_ovf, r.ovf);
                    end
                    last_dp  = o_dp;
                    last_nan = o_nan;
                    last_ovf = o_ovf;
                    held     = 1'b0;
                end
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        beat_t ones;
        beat_t negs;
        beat_t zeros;
        ones     = fill(8'h3C);
        negs     = fill(8'hBC);
        zeros    = fill(8'h00);
        rand_rdy = 1'b0;
        i_ready  = 1'b0;
        last_dp  = 0;
        last_nan = 1'b0;
        last_ovf = 1'b0;

        // Reset held for 2 cycles with a valid beat pending.
        i_rst   = 1'b1;
        i_valid = 1'b1;
        i_last  = 1'b1;
        i_vec_a = ones;
        i_vec_b = ones;
        repeat (2) begin
            @(negedge i_clk);
            check("rst_ready", o_ready, 0);
        end
        @(posedge i_clk);
        #1;
        i_rst   = 1'b0;
        i_valid = 1'b0;
        i_last  = 1'b0;
        @(negedge i_clk);
        check("post_rst_ready", o_ready, 1);
        check("post_rst_valid", o_valid, 0);
        check("post_rst_dp", o_dp, 0);
        check("post_rst_nan", o_nan, 0);
        check("post_rst_ovf", o_ovf, 0);
        @(posedge i_clk);
        #1;

        // Three back-to-back beats of 1.0 x 1.0; result after exactly 2 cycles.
        i_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin va[i] = ones; vb[i] = ones; end
        send_vec(3, 0, 0);
        @(negedge i_clk);
        check("lat_drain_valid", o_valid, 0);
        @(negedge i_clk);
        check("lat_out_valid", o_valid, 1);
        check("lat_out_ready", o_ready, 0);
        @(negedge i_clk);
        check("handshake_next_ready", o_ready, 1);
        check("handshake_next_valid", o_valid, 0);
        check("three_beat_dp", last_dp, 128'sd96 <<< SCALE);
        check("three_beat_nan", last_nan, 0);
        check("three_beat_ovf", last_ovf, 0);
        @(posedge i_clk);
        #1;

        // Same vector with gaps and a 5-cycle output stall.
        i_ready = 1'b0;
        send_vec(3, 2, 2);
        @(negedge i_clk);
        wait_valid("stall_valid_seen");
        check("stall_ready_0", o_ready, 0);
        for (int i = 1; i < 5; i++) begin
            @(negedge i_clk);
            check("stall_valid", o_valid, 1);
            check("stall_ready", o_ready, 0);
        end
        @(posedge i_clk);
        #1;
        i_ready = 1'b1;
        @(negedge i_clk);
        check("hs_cycle_ready", o_ready, 0);
        @(negedge i_clk);
        check("after_hs_ready", o_ready, 1);
        check("after_hs_valid", o_valid, 0);
        check("gap_dp", last_dp, 128'sd96 <<< SCALE);
        @(posedge i_clk);
        #1;

        // Special operand in beat 2, then an all-zero vector clears the flag.
        for (int i = 0; i < 3; i++) begin va[i] = ones; vb[i] = ones; end
        va[1][7] = 8'h7F;
        send_vec(3, 0, 1);
        wait_results();
        check("nan_flag", last_nan, 1);
        check("nan_dp", last_dp, 0);
        va[0] = zeros;
        vb[0] = zeros;
        send_vec(1, 0, 0);
        wait_results();
        check("nan_cleared", last_nan, 0);
        check("zero_dp", last_dp, 0);

        // max_blk+2 beats: only the first max_blk are summed.
        for (int i = 0; i < MAX_BLK + 2; i++) begin va[i] = ones; vb[i] = ones; end
        send_vec(MAX_BLK + 2, 0, 0);
        wait_results();
        check("ovf_flag", last_ovf, 1);
        check("ovf_dp", last_dp, 128'sd256 <<< SCALE);

        // Reset after two accepted beats, then a single 1.0 x -1.0 beat.
        send_beat(ones, ones, 1'b0);
        send_beat(ones, ones, 1'b0);
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        va[0] = ones;
        vb[0] = negs;
        send_vec(1, 0, 0);
        wait_results();
        check("mid_rst_dp", last_dp, -(128'sd32 <<< SCALE));
        check("mid_rst_ovf", last_ovf, 0);

        // Reset while a result is held in OUT discards it.
        i_ready = 1'b0;
        va[0] = ones;
        vb[0] = ones;
        send_vec(1, 0, 0);
        @(negedge i_clk);
        wait_valid("out_rst_valid_seen");
        @(posedge i_clk);
        #1;
        void'(exp_q.pop_back());
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        @(negedge i_clk);
        check("out_rst_valid", o_valid, 0);
        check("out_rst_dp", o_dp, 0);
        check("out_rst_ready", o_ready, 1);
        @(posedge i_clk);
        #1;

        // Random vectors with random gaps and random backpressure.
        rand_rdy = 1'b1;
        for (int v = 0; v < 40; v++) begin
            int n;
            n = $urandom_range(1, MAX_BLK + 2);
            for (int i = 0; i < n; i++) begin
                for (int j = 0; j < K; j++) begin
                    va[i][j] = rand_elem();
                    vb[i][j] = rand_elem();
                end
            end
            send_vec(n, 0, 2);
        end
        wait_results();
        rand_rdy = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
